// File: rtl/sc_parity_framer.sv
// -----------------------------------------------------------------------------
// sc_parity_framer
//
// Serial-to-parallel parity framer for the receive side of a scrambled or
// difference-coded serial link. It takes the single-bit stream from the XOR
// stage, MSB first, collects DATA_WIDTH data bits and then one parity bit,
// checks the parity, and presents the word to the downstream stage with a
// valid/ready handshake.
//
// Parameters
//   DATA_WIDTH  data bits per frame (2..32)
//   PARITY_ODD  0 = even parity, 1 = odd parity
//
// Ports
//   sc_parity_framer_CLOCK_50      in   system clock, rising edge
//   sc_parity_framer_RESET_InLow   in   asynchronous active-low reset
//   sc_parity_framer_clear_In      in   synchronous clear, drops partial/held frame
//   sc_parity_framer_bit_In        in   serial bit, MSB first
//   sc_parity_framer_bitValid_In   in   bit_In is valid this cycle
//   sc_parity_framer_bitReady_Out  out  framer accepts a bit this cycle
//   sc_parity_framer_data_Out      out  assembled data word
//   sc_parity_framer_err_Out       out  parity mismatch for the presented word
//   sc_parity_framer_valid_Out     out  data_Out / err_Out are valid
//   sc_parity_framer_ready_In      in   downstream accepts the word
//   sc_parity_framer_errCnt_Out    out  [7:0] saturating count of bad frames
//                                       (only with SC_PARITY_FRAMER_ERRCNT_EN)
//
// Optional feature macro: SC_PARITY_FRAMER_ERRCNT_EN
// -----------------------------------------------------------------------------
module sc_parity_framer #(
    parameter int DATA_WIDTH = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic                  sc_parity_framer_CLOCK_50,
    input  logic                  sc_parity_framer_RESET_InLow,
    input  logic                  sc_parity_framer_clear_In,
    input  logic                  sc_parity_framer_bit_In,
    input  logic                  sc_parity_framer_bitValid_In,
    output logic                  sc_parity_framer_bitReady_Out,
    output logic [DATA_WIDTH-1:0] sc_parity_framer_data_Out,
    output logic                  sc_parity_framer_err_Out,
    output logic                  sc_parity_framer_valid_Out,
`ifdef SC_PARITY_FRAMER_ERRCNT_EN
    output logic [7:0]            sc_parity_framer_errCnt_Out,
`endif
    input  logic                  sc_parity_framer_ready_In
);

    localparam int   CNT_W    = $clog2(DATA_WIDTH);
    localparam logic PAR_ODD  = 1'(PARITY_ODD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        CHECK   = 2'd1,
        HOLD    = 2'd2
    } state_e;

    state_e                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  par_q;
    logic [DATA_WIDTH-1:0] shreg_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  err_q;
    logic                  valid_q;

    logic                  bit_accept;
    logic                  frame_err;

    // Readiness depends only on the state register, so upstream never sees a
    // combinational path from its own valid back to ready.
    assign sc_parity_framer_bitReady_Out = (state_q != HOLD);
    assign bit_accept = sc_parity_framer_bitValid_In & sc_parity_framer_bitReady_Out;

    // Received parity bit versus the parity expected from the data bits.
    assign frame_err = sc_parity_framer_bit_In != (par_q ^ PAR_ODD);

    assign sc_parity_framer_data_Out  = data_q;
    assign sc_parity_framer_err_Out   = err_q;
    assign sc_parity_framer_valid_Out = valid_q;

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge sc_parity_framer_CLOCK_50 or negedge sc_parity_framer_RESET_InLow) begin
        if (!sc_parity_framer_RESET_InLow) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            shreg_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else if (sc_parity_framer_clear_In) begin
            // NOTE: clear deliberately leaves data_q/err_q alone; only the
            // handshake and frame-assembly state are discarded.
            state_q <= COLLECT;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            shreg_q <= '0;
            valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                COLLECT: begin
                    if (bit_accept) begin
                        shreg_q <= {shreg_q[DATA_WIDTH-2:0], sc_parity_framer_bit_In};
                        par_q   <= par_q ^ sc_parity_framer_bit_In;
                        if (cnt_q == CNT_LAST) begin
                            state_q <= CHECK;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end

                CHECK: begin
                    if (bit_accept) begin
                        data_q  <= shreg_q;
                        err_q   <= frame_err;
                        valid_q <= 1'b1;
                        cnt_q   <= '0;
                        par_q   <= 1'b0;
                        state_q <= HOLD;
                    end
                end

                HOLD: begin
                    if (sc_parity_framer_ready_In) begin
                        valid_q <= 1'b0;
                        state_q <= COLLECT;
                    end
                end

                default: begin
                    state_q <= COLLECT;
                end
            endcase
        end
    end

`ifdef SC_PARITY_FRAMER_ERRCNT_EN
    // Counts frames that enter HOLD with a parity error. Survives clear_In so
    // link-quality statistics are not lost when a frame is flushed.
    logic [7:0] err_cnt_q;
    logic       err_frame_done;

    assign err_frame_done = !sc_parity_framer_clear_In && (state_q == CHECK)
                            && bit_accept && frame_err;

    always_ff @(posedge sc_parity_framer_CLOCK_50 or negedge sc_parity_framer_RESET_InLow) begin
        if (!sc_parity_framer_RESET_InLow) begin
            err_cnt_q <= 8'd0;
        end else if (err_frame_done && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign sc_parity_framer_errCnt_Out = err_cnt_q;
`endif

`ifndef SYNTHESIS
    // A presented word stays put until the handshake, clear or reset.
    a_hold_stable: assert property (
        @(posedge sc_parity_framer_CLOCK_50) disable iff (!sc_parity_framer_RESET_InLow)
        (valid_q && !sc_parity_framer_ready_In && !sc_parity_framer_clear_In)
        |=> (valid_q && $stable(data_q) && $stable(err_q))
    );

    // valid_Out is high exactly while the framer is in HOLD.
    a_valid_is_hold: assert property (
        @(posedge sc_parity_framer_CLOCK_50) disable iff (!sc_parity_framer_RESET_InLow)
        valid_q == (state_q == HOLD)
    );
`endif

endmodule

// File: tb/tb_sc_parity_framer.sv
module tb_sc_parity_framer;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         clear;
    logic         bit_in;
    logic         bit_valid;
    logic         ready;
    logic         bit_ready;
    logic [W-1:0] data_out;
    logic         err_out;
    logic         valid_out;
    logic         bit_ready_odd;
    logic [W-1:0] data_out_odd;
    logic         err_out_odd;
    logic         valid_out_odd;
`ifdef SC_PARITY_FRAMER_ERRCNT_EN
    logic [7:0]   err_cnt;
    logic [7:0]   err_cnt_odd;
`endif

    int checks   = 0;
    int failures = 0;

    // Even-parity and odd-parity instances share the same stimulus.
    sc_parity_framer #(.DATA_WIDTH(W), .PARITY_ODD(0)) dut (
        .sc_parity_framer_CLOCK_50     (clk),
        .sc_parity_framer_RESET_InLow  (rst_n),
        .sc_parity_framer_clear_In     (clear),
        .sc_parity_framer_bit_In       (bit_in),
        .sc_parity_framer_bitValid_In  (bit_valid),
        .sc_parity_framer_bitReady_Out (bit_ready),
        .sc_parity_framer_data_Out     (data_out),
        .sc_parity_framer_err_Out      (err_out),
        .sc_parity_framer_valid_Out    (valid_out),
`ifdef SC_PARITY_FRAMER_ERRCNT_EN
        .sc_parity_framer_errCnt_Out   (err_cnt),
`endif
        .sc_parity_framer_ready_In     (ready)
    );

    sc_parity_framer #(.DATA_WIDTH(W), .PARITY_ODD(1)) dut_odd (
        .sc_parity_framer_CLOCK_50     (clk),
        .sc_parity_framer_RESET_InLow  (rst_n),
        .sc_parity_framer_clear_In     (clear),
        .sc_parity_framer_bit_In       (bit_in),
        .sc_parity_framer_bitValid_In  (bit_valid),
        .sc_parity_framer_bitReady_Out (bit_ready_odd),
        .sc_parity_framer_data_Out     (data_out_odd),
        .sc_parity_framer_err_Out      (err_out_odd),
        .sc_parity_framer_valid_Out    (valid_out_odd),
`ifdef SC_PARITY_FRAMER_ERRCNT_EN
        .sc_parity_framer_errCnt_Out   (err_cnt_odd),
`endif
        .sc_parity_framer_ready_In     (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Present one bit for exactly one rising edge, then drop bitValid_In.
    task automatic send_bit(input logic b);
        @(negedge clk);
        bit_in    = b;
        bit_valid = 1'b1;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
    endtask

    // MSB-first data bits, optional idle cycles, then the parity bit.
    task automatic send_frame(input logic [W-1:0] d, input logic p, input int gap);
        for (int i = W - 1; i >= 0; i--) begin
            send_bit(d[i]);
            repeat (gap) @(negedge clk);
        end
        send_bit(p);
    endtask

    typedef struct {
        logic [W-1:0] data;
        logic         par;
        logic         exp_err_even;
        logic         exp_err_odd;
    } vec_t;

    vec_t vecs [8];

    initial begin
        // data, parity bit, expected err (even), expected err (odd)
        vecs[0] = '{8'hB2, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{8'hB2, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{8'hFF, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{8'h01, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{8'h80, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{8'h7E, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{8'hA5, 1'b0, 1'b0, 1'b1};

        rst_n     = 1'b0;
        clear     = 1'b0;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        ready     = 1'b1;

        // Reset state.
        #1;
        check("rst_bitready", bit_ready, 1'b1);
        check("rst_valid",    valid_out, 1'b0);
        check("rst_data",     data_out,  8'h00);
        check("rst_err",      err_out,   1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven frames with ready_In held high.
        for (int v = 0; v < 8; v++) begin
            send_frame(vecs[v].data, vecs[v].par, 0);
            check($sformatf("v%0d_valid", v),    valid_out,   1'b1);
            check($sformatf("v%0d_data", v),     data_out,    vecs[v].data);
            check($sformatf("v%0d_err", v),      err_out,     vecs[v].exp_err_even);
            check($sformatf("v%0d_err_odd", v),  err_out_odd, vecs[v].exp_err_odd);
            check($sformatf("v%0d_bitready", v), bit_ready,   1'b0);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_valid_drop", v), valid_out, 1'b0);
            check($sformatf("v%0d_bitready_back", v), bit_ready, 1'b1);
            check($sformatf("v%0d_data_kept", v), data_out, vecs[v].data);
        end

        // Gaps between bits stall the frame without changing it: 0xC3 p1 -> err.
        send_frame(8'hC3, 1'b1, 2);
        check("gap_valid", valid_out, 1'b1);
        check("gap_data",  data_out,  8'hC3);
        check("gap_err",   err_out,   1'b1);
        @(posedge clk);
        #1;

        // Backpressure: ready low for 5 cycles while upstream keeps offering.
        ready = 1'b0;
        send_frame(8'hB2, 1'b0, 0);
        bit_in    = 1'b0;
        bit_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp%0d_valid", c),    valid_out, 1'b1);
            check($sformatf("bp%0d_data", c),     data_out,  8'hB2);
            check($sformatf("bp%0d_err", c),      err_out,   1'b0);
            check($sformatf("bp%0d_bitready", c), bit_ready, 1'b0);
        end
        @(negedge clk);
        ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid",    valid_out, 1'b0);
        check("bp_release_bitready", bit_ready, 1'b1);
        // The offered MSB (0) of 0x3C is taken only after the handshake.
        send_frame(8'h3C, 1'b0, 0);
        check("bp_next_data", data_out, 8'h3C);
        check("bp_next_err",  err_out,  1'b0);
        @(posedge clk);
        #1;

        // Clear mid-frame: partial bits and the same-cycle bit are discarded.
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        @(negedge clk);
        clear     = 1'b1;
        bit_in    = 1'b1;
        bit_valid = 1'b1;
        @(posedge clk);
        #1;
        clear     = 1'b0;
        bit_valid = 1'b0;
        check("clr_valid",     valid_out, 1'b0);
        check("clr_bitready",  bit_ready, 1'b1);
        check("clr_data_kept", data_out,  8'h3C);
        send_frame(8'hFF, 1'b0, 0);
        check("clr_frame_valid", valid_out, 1'b1);
        check("clr_frame_data",  data_out,  8'hFF);
        check("clr_frame_err",   err_out,   1'b0);
        @(posedge clk);
        #1;

        // Clear while holding a word: handshake dropped, word and flag kept.
        ready = 1'b0;
        send_frame(8'h81, 1'b1, 0);
        check("clrh_err", err_out, 1'b1);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        check("clrh_valid",    valid_out, 1'b0);
        check("clrh_bitready", bit_ready, 1'b1);
        check("clrh_data",     data_out,  8'h81);
        check("clrh_err_kept", err_out,   1'b1);
        ready = 1'b1;

        // Asynchronous reset between edges while in HOLD.
        ready = 1'b0;
        send_frame(8'hB2, 1'b1, 0);
        check("arst_pre_valid", valid_out, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_valid",    valid_out, 1'b0);
        check("arst_data",     data_out,  8'h00);
        check("arst_err",      err_out,   1'b0);
        check("arst_bitready", bit_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        ready = 1'b1;
        send_frame(8'h5A, 1'b0, 0);
        check("arst_clean_valid", valid_out, 1'b1);
        check("arst_clean_data",  data_out,  8'h5A);
        check("arst_clean_err",   err_out,   1'b0);
        @(posedge clk);
        #1;

`ifdef SC_PARITY_FRAMER_ERRCNT_EN
        // Saturating bad-frame counter.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("ecnt_rst0", err_cnt, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int f = 0; f < 260; f++) begin
            send_frame(8'h00, 1'b1, 0);
            if (f == 2) check("ecnt_3", err_cnt, 8'd3);
            @(posedge clk);
            #1;
        end
        check("ecnt_sat", err_cnt, 8'd255);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        check("ecnt_after_clear", err_cnt, 8'd255);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("ecnt_after_rst", err_cnt, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
`endif

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
